tmds_word_aligner: RTL and testbench

TMDS_WORD_ALIGNER -- requirements
Module: tmds_word_aligner

---
 rtl/tmds_pkg.sv | 42 ++++
 rtl/tmds_ctrl_detect.sv | 17 +
 rtl/tmds_word_aligner.sv | 160 ++++++++++++++++
 tb/tb_tmds_word_aligner.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: control-token codes, aligner states and token decoding.
// Used by tmds_word_aligner (optional build macro TMDS_RX_INVERT_EN) and tmds_ctrl_detect.
package tmds_pkg;

    localparam int unsigned SYM_W      = 10;
    localparam logic [3:0]  OFFSET_MAX = 4'd9;

    localparam logic [SYM_W-1:0] TOK_C00 = 10'h354;
    localparam logic [SYM_W-1:0] TOK_C01 = 10'h0AB;
    localparam logic [SYM_W-1:0] TOK_C10 = 10'h154;
    localparam logic [SYM_W-1:0] TOK_C11 = 10'h2AB;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } align_state_e;

    typedef struct packed {
        logic       is_token;
        logic [1:0] ctrl;
    } ctrl_info_t;

    function automatic ctrl_info_t token_to_ctrl(input logic [SYM_W-1:0] sym);
        ctrl_info_t info;
        info = '0;
        case (sym)
            TOK_C00: info = '{is_token: 1'b1, ctrl: 2'b00};
            TOK_C01: info = '{is_token: 1'b1, ctrl: 2'b01};
            TOK_C10: info = '{is_token: 1'b1, ctrl: 2'b10};
            TOK_C11: info = '{is_token: 1'b1, ctrl: 2'b11};
            default: info = '0;
        endcase
        return info;
    endfunction

    // Window offsets run 0..9 and wrap back to 0.
    function automatic logic [3:0] next_offset(input logic [3:0] off);
        return (off >= OFFSET_MAX) ? 4'd0 : off + 4'd1;
    endfunction

endpackage

// File: rtl/tmds_ctrl_detect.sv
// Combinational classifier: 10-bit TMDS symbol -> {is_token, ctrl}.
// Shared between the receive aligner and the transmit-side test model.
module tmds_ctrl_detect
    import tmds_pkg::*;
(
    input  logic [SYM_W-1:0] i_symbol,
    output logic             o_is_token,
    output logic [1:0]       o_ctrl
);

    ctrl_info_t w_info;

    assign w_info     = token_to_ctrl(i_symbol);
    assign o_is_token = w_info.is_token;
    assign o_ctrl     = w_info.ctrl;

endmodule

// File: rtl/tmds_word_aligner.sv
// TMDS word aligner: slides a 10-bit window across two raw words until control tokens lock it.
// Define TMDS_RX_INVERT_EN to invert raw_word at the input (swapped differential pair on the board).
module tmds_word_aligner
    import tmds_pkg::*;
#(
    parameter int LOCK_HITS      = 8,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int LOSS_TIMEOUT   = 4096
) (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic [SYM_W-1:0] raw_word,
    output logic [SYM_W-1:0] aligned_word,
    output logic             ctrl_token,
    output logic [1:0]       ctrl,
    output logic             locked,
    output logic [3:0]       bit_offset
);

    localparam int ST_W  = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
    localparam int LT_W  = (LOSS_TIMEOUT > 1) ? $clog2(LOSS_TIMEOUT) : 1;
    localparam int HIT_W = (LOCK_HITS > 0) ? $clog2(LOCK_HITS + 1) : 1;

    localparam logic [ST_W-1:0]  SEARCH_LAST = ST_W'(SEARCH_TIMEOUT - 1);
    localparam logic [LT_W-1:0]  LOSS_LAST   = LT_W'(LOSS_TIMEOUT - 1);
    localparam logic [HIT_W-1:0] HITS_LOCK   = HIT_W'(LOCK_HITS);

    logic [SYM_W-1:0] w_raw;
    logic [18:0]      w_span;
    logic [SYM_W-1:0] w_window;
    logic             w_is_token;
    logic [1:0]       w_ctrl;
    logic [HIT_W-1:0] w_hits_next;

    logic [SYM_W-1:0] r_prev;
    logic [SYM_W-1:0] r_aligned;
    logic             r_token;
    logic [1:0]       r_ctrl;
    align_state_e     r_state;
    logic [3:0]       r_offset;
    logic [ST_W-1:0]  r_search_tmr;
    logic [LT_W-1:0]  r_loss_tmr;
    logic [HIT_W-1:0] r_hits;
    logic             r_locked;

`ifdef TMDS_RX_INVERT_EN
    assign w_raw = ~raw_word;
`else
    assign w_raw = raw_word;
`endif

    // Older word sits in the low bits because bit 0 is received first; offset 9 needs only raw[8:0].
    assign w_span = {w_raw[8:0], r_prev};

    always_comb begin
        w_window = w_span[9:0];
        case (r_offset)
            4'd1:    w_window = w_span[10:1];
            4'd2:    w_window = w_span[11:2];
            4'd3:    w_window = w_span[12:3];
            4'd4:    w_window = w_span[13:4];
            4'd5:    w_window = w_span[14:5];
            4'd6:    w_window = w_span[15:6];
            4'd7:    w_window = w_span[16:7];
            4'd8:    w_window = w_span[17:8];
            4'd9:    w_window = w_span[18:9];
            default: w_window = w_span[9:0];
        endcase
    end

    tmds_ctrl_detect u_detect (
        .i_symbol   (w_window),
        .o_is_token (w_is_token),
        .o_ctrl     (w_ctrl)
    );

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_prev    <= '0;
            r_aligned <= '0;
            r_token   <= 1'b0;
            r_ctrl    <= 2'b00;
        end else begin
            r_prev    <= w_raw;
            r_aligned <= w_window;
            r_token   <= w_is_token;
            r_ctrl    <= w_ctrl;
        end
    end

    // First hit of a run always restarts the count at 1; later hits saturate at LOCK_HITS.
    always_comb begin
        if (r_state == ST_CONFIRM) begin
            w_hits_next = (r_hits >= HITS_LOCK) ? HITS_LOCK : r_hits + 1'b1;
        end else begin
            w_hits_next = HIT_W'(1);
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_state      <= ST_SEARCH;
            r_offset     <= 4'd0;
            r_search_tmr <= '0;
            r_loss_tmr   <= '0;
            r_hits       <= '0;
            r_locked     <= 1'b0;
        end else begin
            case (r_state)
                ST_SEARCH, ST_CONFIRM: begin
                    // A token seen on the expiry cycle wins: the offset stays put.
                    if (w_is_token) begin
                        r_hits <= w_hits_next;
                        if (w_hits_next >= HITS_LOCK) begin
                            r_state      <= ST_LOCKED;
                            r_locked     <= 1'b1;
                            r_loss_tmr   <= '0;
                            r_search_tmr <= '0;
                        end else begin
                            r_state <= ST_CONFIRM;
                        end
                    end else if (r_search_tmr == SEARCH_LAST) begin
                        r_state      <= ST_SEARCH;
                        r_offset     <= next_offset(r_offset);
                        r_search_tmr <= '0;
                        r_hits       <= '0;
                    end else begin
                        r_state      <= ST_SEARCH;
                        r_search_tmr <= r_search_tmr + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (w_is_token) begin
                        r_loss_tmr <= '0;
                    end else if (r_loss_tmr == LOSS_LAST) begin
                        r_state      <= ST_SEARCH;
                        r_locked     <= 1'b0;
                        r_offset     <= next_offset(r_offset);
                        r_loss_tmr   <= '0;
                        r_search_tmr <= '0;
                        r_hits       <= '0;
                    end else begin
                        r_loss_tmr <= r_loss_tmr + 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_SEARCH;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign aligned_word = r_aligned;
    assign ctrl_token   = r_token;
    assign ctrl         = r_ctrl;
    assign locked       = r_locked;
    assign bit_offset   = r_offset;

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Directed bench for tmds_word_aligner: a serializer model builds raw words, a scoreboard checks outputs.
// Build with TMDS_RX_INVERT_EN to drive the physically inverted lane.
module tb_tmds_word_aligner;

    localparam int LH = 8;
    localparam int ST = 16;
    localparam int LT = 16;

    localparam logic [9:0] T00  = 10'h354;
    localparam logic [9:0] T01  = 10'h0AB;
    localparam logic [9:0] T10  = 10'h154;
    localparam logic [9:0] T11  = 10'h2AB;
    localparam logic [9:0] DATA = 10'h2CC;

    typedef struct {
        string      tag;
        logic [9:0] aw;
        logic       tok;
        logic [1:0] c;
        bit         chk_word;
        logic       lk;
        logic [3:0] off;
        bit         chk_state;
    } exp_t;

    logic       clk_pixel = 1'b0;
    logic       reset;
    logic [9:0] raw_word;
    logic [9:0] aligned_word;
    logic       ctrl_token;
    logic [1:0] ctrl;
    logic       locked;
    logic [3:0] bit_offset;

    logic [9:0] m_sym;
    logic       m_tok;
    logic [1:0] m_ctrl;

    int         n_checks = 0;
    int         n_errors = 0;
    int         o;
    logic [9:0] cur;
    logic [9:0] toks [4];
    exp_t       sb [$];

    always #5 clk_pixel = ~clk_pixel;

    tmds_word_aligner #(
        .LOCK_HITS      (LH),
        .SEARCH_TIMEOUT (ST),
        .LOSS_TIMEOUT   (LT)
    ) dut (
        .clk_pixel    (clk_pixel),
        .reset        (reset),
        .raw_word     (raw_word),
        .aligned_word (aligned_word),
        .ctrl_token   (ctrl_token),
        .ctrl         (ctrl),
        .locked       (locked),
        .bit_offset   (bit_offset)
    );

    // Transmit-side symbol classifier, used to vet the stimulus symbols.
    tmds_ctrl_detect u_tx_class (
        .i_symbol   (m_sym),
        .o_is_token (m_tok),
        .o_ctrl     (m_ctrl)
    );

    function automatic logic [2:0] ref_tok(input logic [9:0] s);
        case (s)
            10'h354: return 3'b100;
            10'h0AB: return 3'b101;
            10'h154: return 3'b110;
            10'h2AB: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    // Raw word whose low `off` bits finish symbol c and whose upper bits start symbol n.
    function automatic logic [9:0] mk_raw(input logic [9:0] c, input logic [9:0] n, input int off);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) begin
            if (i < off) r[i] = c[10 - off + i];
            else         r[i] = n[i - off];
        end
        return r;
    endfunction

    function automatic logic [9:0] phys(input logic [9:0] w);
`ifdef TMDS_RX_INVERT_EN
        return ~w;
`else
        return w;
`endif
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_entry(input exp_t e);
        if (e.chk_word) begin
            chk({e.tag, ".aligned_word"}, 16'(aligned_word), 16'(e.aw));
            chk({e.tag, ".ctrl_token"}, 16'(ctrl_token), 16'(e.tok));
            chk({e.tag, ".ctrl"}, 16'(ctrl), 16'(e.c));
        end
        if (e.chk_state) begin
            chk({e.tag, ".locked"}, 16'(locked), 16'(e.lk));
            chk({e.tag, ".bit_offset"}, 16'(bit_offset), 16'(e.off));
        end
    endtask

    // Sends one raw word; the window completes the previously queued symbol.
    task automatic tx(input logic [9:0] nxt, input bit cw, input bit cs,
                      input logic lk, input logic [3:0] off, input string tag);
        exp_t       e;
        logic [2:0] t;
        raw_word = phys(mk_raw(cur, nxt, o));
        t = ref_tok(cur);
        e.tag = tag; e.aw = cur; e.tok = t[2]; e.c = t[1:0];
        e.chk_word = cw; e.lk = lk; e.off = off; e.chk_state = cs;
        if (cw || cs) sb.push_back(e);
        cur = nxt;
        @(posedge clk_pixel);
        #1;
        if (sb.size() > 0) check_entry(sb.pop_front());
    endtask

    task automatic send(input logic [9:0] nxt);
        tx(nxt, 1'b0, 1'b0, 1'b0, 4'd0, "");
    endtask

    task automatic do_reset(input int n, input string tag);
        exp_t e;
        reset = 1'b1;
        raw_word = '0;
        e.tag = tag; e.aw = '0; e.tok = 1'b0; e.c = 2'b00;
        e.chk_word = 1'b1; e.lk = 1'b0; e.off = 4'd0; e.chk_state = 1'b1;
        sb.push_back(e);
        repeat (n) @(posedge clk_pixel);
        #1;
        check_entry(sb.pop_front());
        reset = 1'b0;
        cur = '0;
    endtask

    task automatic wait_lock(input logic [9:0] sym, input int budget, input string tag);
        int n;
        n = 0;
        while (locked !== 1'b1 && n < budget) begin
            send(sym);
            n++;
        end
        chk({tag, ".lock_within_budget"}, 16'(locked), 16'd1);
    endtask

    task automatic vet(input logic [9:0] sym);
        logic [2:0] t;
        m_sym = sym;
        #1;
        t = ref_tok(sym);
        chk("vet.is_token", 16'(m_tok), 16'(t[2]));
        chk("vet.ctrl", 16'(m_ctrl), 16'(t[1:0]));
    endtask

    // Loss sequence: one window still holds the last token, then LT data windows drop lock.
    task automatic lose_lock(input logic [3:0] off_now, input logic [3:0] off_after, input string tag);
        tx(DATA, 1'b1, 1'b1, 1'b1, off_now, {tag, ".last_token"});
        repeat (LT - 2) send(DATA);
        tx(DATA, 1'b1, 1'b1, 1'b1, off_now, {tag, ".hold"});
        tx(DATA, 1'b0, 1'b1, 1'b0, off_after, {tag, ".dropped"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        raw_word = '0;
        o = 0;
        cur = '0;
        m_sym = '0;
        toks[0] = T00; toks[1] = T01; toks[2] = T10; toks[3] = T11;

        vet(T00); vet(T01); vet(T10); vet(T11); vet(DATA); vet(10'h355);

        do_reset(2, "reset");

        // 0x354 rotated by 3 bits: lock must land on offset 3, then lose lock to offset 4
        o = 3;
        wait_lock(T00, 3 * ST + LH + 2, "rot3");
        tx(T00, 1'b1, 1'b1, 1'b1, 4'd3, "rot3.aligned");
        lose_lock(4'd3, 4'd4, "loss3");

        // Lock at offset 9, reset while locked, then relock and lose lock across the 9->0 wrap
        do_reset(1, "rot9.reset");
        o = 9;
        wait_lock(T11, 9 * ST + LH + 2, "rot9");
        tx(T11, 1'b1, 1'b1, 1'b1, 4'd9, "rot9.aligned");
        do_reset(1, "reset_locked");
        repeat (LH) send(T11);
        chk("reset_locked.no_retained_lock", 16'(locked), 16'd0);
        wait_lock(T11, 9 * ST + LH + 2, "rot9b");
        lose_lock(4'd9, 4'd0, "loss9");

        // Seven tokens, one data symbol, then eight tokens at offset 0
        do_reset(1, "hits.reset");
        o = 0;
        for (int i = 0; i < 7; i++) tx(toks[i % 4], 1'b1, 1'b1, 1'b0, 4'd0, "hits.pre");
        tx(DATA, 1'b1, 1'b1, 1'b0, 4'd0, "hits.seventh");
        for (int i = 0; i < 8; i++) tx(toks[i % 4], 1'b1, 1'b1, 1'b0, 4'd0, "hits.post");
        tx(T00, 1'b1, 1'b1, 1'b1, 4'd0, "hits.locked");

        // Token on the exact search-timer expiry cycle
        do_reset(1, "tie.reset");
        o = 0;
        repeat (ST - 2) send(10'h000);
        tx(T01, 1'b0, 1'b1, 1'b0, 4'd0, "tie.before");
        tx(T01, 1'b1, 1'b1, 1'b0, 4'd0, "tie.expiry");
        repeat (LH - 3) send(T01);
        tx(T01, 1'b0, 1'b1, 1'b0, 4'd0, "tie.confirm7");
        tx(T01, 1'b1, 1'b1, 1'b1, 4'd0, "tie.confirm8");

        // 0x0AB lane (driven inverted when TMDS_RX_INVERT_EN is defined)
        do_reset(1, "inv.reset");
        o = 2;
        wait_lock(T01, 2 * ST + LH + 2, "inv");
        tx(T01, 1'b1, 1'b1, 1'b1, 4'd2, "inv.aligned");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
